life_scheduler: RTL

Frame-level sequencer for the life_logic pass engine. It launches one next-state pass per display frame when running, single-steps when paused, and swaps the double_buffer read/write halves only after a pass completes. It also owns the double_buffer write port. The port is driven by life_logic during a pass, or by an internal zero-fill sweep on a clear request.

---
 rtl/life_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/life_scheduler.sv
// Frame-level sequencer for the life_logic pass engine: launches one pass per frame,
// swaps double_buffer halves on completion, and owns the double_buffer write port.
module life_scheduler #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DONE_MASK = 4,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              frame_in,
  input  logic              pause_in,
  input  logic              step_in,
  input  logic              clear_in,
  input  logic              life_done_in,
  input  logic              life_wr_en_in,
  input  logic [ADDR_W-1:0] life_addr_w_in,
  input  logic [WORD_W-1:0] life_data_w_in,
  output logic              life_start_out,
  output logic              buf_sel_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] addr_w_out,
  output logic [WORD_W-1:0] data_w_out,
  output logic [15:0]       gen_count_out,
  output logic [7:0]        overrun_count_out,
  output logic              timeout_out,
  output logic              busy_out
);

  localparam int unsigned MASK_W = (DONE_MASK < 1) ? 1 : $clog2(DONE_MASK + 1);
  localparam int unsigned TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_SWAP,
    S_CLEAR_A,
    S_CLEAR_B
  } state_e;

  state_e              state_q;
  logic [MASK_W-1:0]   mask_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [ADDR_W-1:0]   sweep_q;
  logic                step_pending_q;
  logic                clear_pending_q;
  logic                life_start_q;
  logic                buf_sel_q;
  logic [15:0]         gen_q;
  logic [7:0]          overrun_q;
  logic                timeout_q;
  logic                busy_q;

  logic                mask_done;
  assign mask_done = (mask_q == MASK_W'(DONE_MASK));

  // NOTE: every register below is assigned with <= so that all of them see the
  // pre-edge values of each other; blocking here would create ordering races.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= S_IDLE;
      mask_q          <= '0;
      to_cnt_q        <= '0;
      sweep_q         <= '0;
      step_pending_q  <= 1'b0;
      clear_pending_q <= 1'b0;
      life_start_q    <= 1'b0;
      buf_sel_q       <= 1'b0;
      gen_q           <= '0;
      overrun_q       <= '0;
      timeout_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      life_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_in) begin
            if (clear_pending_q) begin
              state_q <= S_CLEAR_A;
              sweep_q <= '0;
              busy_q  <= 1'b1;
            end else if (!pause_in || step_pending_q) begin
              state_q      <= S_LAUNCH;
              life_start_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          mask_q   <= '0;
          to_cnt_q <= '0;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (frame_in && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
          if (!mask_done) mask_q <= mask_q + MASK_W'(1);
          // done may still be high from the previous pass until the mask expires
          if (life_done_in && mask_done) begin
            state_q <= S_SWAP;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_SWAP: begin
          buf_sel_q      <= ~buf_sel_q;
          gen_q          <= gen_q + 16'd1;
          step_pending_q <= 1'b0;
          state_q        <= S_IDLE;
          busy_q         <= 1'b0;
        end
        S_CLEAR_A: begin
          sweep_q <= sweep_q + ADDR_W'(1);
          if (sweep_q == '1) begin
            buf_sel_q <= ~buf_sel_q;
            state_q   <= S_CLEAR_B;
          end
        end
        S_CLEAR_B: begin
          sweep_q <= sweep_q + ADDR_W'(1);
          if (sweep_q == '1) begin
            buf_sel_q       <= ~buf_sel_q;
            gen_q           <= '0;
            clear_pending_q <= 1'b0;
            step_pending_q  <= 1'b0;
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // New requests win over a same-cycle consume so none is lost
      if (clear_in)             clear_pending_q <= 1'b1;
      if (step_in && pause_in)  step_pending_q  <= 1'b1;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned
  // (which would infer a latch).
  always_comb begin
    wr_en_out  = 1'b0;
    addr_w_out = '0;
    data_w_out = '0;
    case (state_q)
      S_RUN: begin
        wr_en_out  = life_wr_en_in;
        addr_w_out = life_addr_w_in;
        data_w_out = life_data_w_in;
      end
      S_CLEAR_A, S_CLEAR_B: begin
        wr_en_out  = 1'b1;
        addr_w_out = sweep_q;
      end
      default: ;
    endcase
  end

  assign life_start_out    = life_start_q;
  assign buf_sel_out       = buf_sel_q;
  assign gen_count_out     = gen_q;
  assign overrun_count_out = overrun_q;
  assign timeout_out       = timeout_q;
  assign busy_out          = busy_q;

endmodule
